// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-ported memory bus between the instruction fetch (IF)
// stage and the data load/store (ME) stage. Each cycle it picks one
// requester, registers that stage's command onto the bus and holds it until
// the memory acknowledges. It then returns a one-cycle ack with the read data
// to the stage that owned the bus. The stall outputs freeze each stage while
// its access is still outstanding.
//
// Parameters
//   ADDR_W      address width
//   DATA_W      data width; byte enables are DATA_W/8 wide
//   STARVE_MAX  number of consecutive ties IF may lose before it is forced
//               to win (1..15)
//   TIMEOUT     grant cycles without iMemAck before the access is aborted
//               (used only when ARB_TIMEOUT_EN is defined; >= 1)
//
// Optional feature macro
//   ARB_TIMEOUT_EN  when defined, a stuck access is aborted after TIMEOUT
//                   grant cycles and the owner gets an ack with err=1.
//                   When undefined, a grant is held until iMemAck and the
//                   err outputs are tied to 0.
//
// Ports
//   iClk, iRst                 clock, synchronous active-high reset
//   iIfReq/iIfAddr             IF read request and fetch address
//   oIfAck/oIfRData/oIfErr     IF completion pulse, fetched word, abort flag
//   oIfStall                   IF request still outstanding
//   iMeReq/iMeWe/iMeBe/
//   iMeAddr/iMeWData           ME request, store flag, byte enables,
//                              address and store data
//   oMeAck/oMeRData/oMeErr     ME completion pulse, load data, abort flag
//   oMeStall                   ME request still outstanding
//   oMemReq/oMemWe/oMemBe/
//   oMemAddr/oMemWData         registered bus command
//   iMemAck/iMemRData          bus completion and read data
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iIfReq,
   input  logic [ADDR_W-1:0]   iIfAddr,
   output logic                oIfAck,
   output logic [DATA_W-1:0]   oIfRData,
   output logic                oIfErr,
   output logic                oIfStall,
   input  logic                iMeReq,
   input  logic                iMeWe,
   input  logic [DATA_W/8-1:0] iMeBe,
   input  logic [ADDR_W-1:0]   iMeAddr,
   input  logic [DATA_W-1:0]   iMeWData,
   output logic                oMeAck,
   output logic [DATA_W-1:0]   oMeRData,
   output logic                oMeErr,
   output logic                oMeStall,
   output logic                oMemReq,
   output logic                oMemWe,
   output logic [DATA_W/8-1:0] oMemBe,
   output logic [ADDR_W-1:0]   oMemAddr,
   output logic [DATA_W-1:0]   oMemWData,
   input  logic                iMemAck,
   input  logic [DATA_W-1:0]   iMemRData
);

   localparam int BE_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G_IF = 2'd1,
      G_ME = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          starve_q, starve_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [BE_W-1:0]     mem_be_q, mem_be_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                if_ack_q, if_ack_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic                me_ack_q, me_ack_d;
   logic [DATA_W-1:0]   me_rdata_q, me_rdata_d;

`ifdef ARB_TIMEOUT_EN
   // The timer only has to reach TIMEOUT-1: expiry is detected during the
   // last waiting grant cycle, not one cycle later.
   localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   logic [TIMER_W-1:0]  timer_q, timer_d;
   logic                if_err_q, if_err_d;
   logic                me_err_q, me_err_d;
`else
   // Without the abort path the timeout length has no meaning.
   logic                timeout_unused;
   assign timeout_unused = (TIMEOUT > 0);
`endif

   logic if_elig;
   logic me_elig;
   logic if_forced;

   // A stage that is being acked this cycle still shows its old request, so
   // it is masked out to avoid servicing the same access twice. IF becomes
   // forced once it has lost STARVE_MAX ties in a row.
   always_comb begin
      if_elig   = iIfReq & ~if_ack_q;
      me_elig   = iMeReq & ~me_ack_q;
      if_forced = if_elig & (starve_q == 4'(STARVE_MAX));
   end

   // Next-state logic. In IDLE, ME wins ties because it carries the older
   // instruction, unless IF has starved long enough to be forced. IF only
   // wins unforced when ME shows no request at all, even a masked one, so a
   // stage renewing right after its ack keeps its turn. In a grant state the
   // command is frozen until iMemAck (or expiry) returns the FSM to IDLE and
   // raises the owner's ack for exactly one cycle.
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_ack_d    = 1'b0;
      me_ack_d    = 1'b0;
      if_rdata_d  = if_rdata_q;
      me_rdata_d  = me_rdata_q;
`ifdef ARB_TIMEOUT_EN
      timer_d     = '0;
      if_err_d    = if_err_q;
      me_err_d    = me_err_q;
`endif
      case (state_q)
         IDLE: begin
            if (me_elig && !if_forced) begin
               state_d     = G_ME;
               mem_req_d   = 1'b1;
               mem_we_d    = iMeWe;
               mem_be_d    = iMeBe;
               mem_addr_d  = iMeAddr;
               mem_wdata_d = iMeWData;
               if (if_elig) begin
                  starve_d = starve_q + 4'd1;
               end
            end else if (if_elig && (!iMeReq || if_forced)) begin
               state_d     = G_IF;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b0;
               mem_be_d    = '1;
               mem_addr_d  = iIfAddr;
               mem_wdata_d = '0;
               starve_d    = '0;
            end
         end
         G_IF, G_ME: begin
            if (iMemAck) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == G_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = iMemRData;
               end else begin
                  me_ack_d   = 1'b1;
                  me_rdata_d = mem_we_q ? '0 : iMemRData;
               end
`ifdef ARB_TIMEOUT_EN
               if_err_d = (state_q == G_IF) ? 1'b0 : if_err_q;
               me_err_d = (state_q == G_ME) ? 1'b0 : me_err_q;
`endif
            end
`ifdef ARB_TIMEOUT_EN
            else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               if (state_q == G_IF) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = '0;
                  if_err_d   = 1'b1;
               end else begin
                  me_ack_d   = 1'b1;
                  me_rdata_d = '0;
                  me_err_d   = 1'b1;
               end
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
`endif
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State register. Reset abandons any access in flight: the bus request
   // drops on the next edge and no ack is produced for it.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_ack_q    <= 1'b0;
         if_rdata_q  <= '0;
         me_ack_q    <= 1'b0;
         me_rdata_q  <= '0;
`ifdef ARB_TIMEOUT_EN
         timer_q     <= '0;
         if_err_q    <= 1'b0;
         me_err_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ack_q    <= if_ack_d;
         if_rdata_q  <= if_rdata_d;
         me_ack_q    <= me_ack_d;
         me_rdata_q  <= me_rdata_d;
`ifdef ARB_TIMEOUT_EN
         timer_q     <= timer_d;
         if_err_q    <= if_err_d;
         me_err_q    <= me_err_d;
`endif
      end
   end

   // Outputs are straight from the registers; only the stalls are
   // combinational so a stage is released in the same cycle as its ack.
   assign oIfAck    = if_ack_q;
   assign oIfRData  = if_rdata_q;
   assign oIfStall  = iIfReq & ~if_ack_q;
   assign oMeAck    = me_ack_q;
   assign oMeRData  = me_rdata_q;
   assign oMeStall  = iMeReq & ~me_ack_q;
   assign oMemReq   = mem_req_q;
   assign oMemWe    = mem_we_q;
   assign oMemBe    = mem_be_q;
   assign oMemAddr  = mem_addr_q;
   assign oMemWData = mem_wdata_q;
`ifdef ARB_TIMEOUT_EN
   assign oIfErr    = if_err_q;
   assign oMeErr    = me_err_q;
`else
   assign oIfErr    = 1'b0;
   assign oMeErr    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter. Each request pushes its expected ack
// (data, err) into a per-stage queue, and each expected bus grant is pushed
// into a bus queue. A separate monitor pops and compares whenever the DUT
// raises an ack or starts a new bus request. A simple memory model acks after
// a programmable number of grant cycles (0 = never).
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } ack_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   logic        iClk = 1'b0;
   logic        iRst;
   logic        iIfReq;
   logic [31:0] iIfAddr;
   logic        oIfAck;
   logic [31:0] oIfRData;
   logic        oIfErr;
   logic        oIfStall;
   logic        iMeReq;
   logic        iMeWe;
   logic [3:0]  iMeBe;
   logic [31:0] iMeAddr;
   logic [31:0] iMeWData;
   logic        oMeAck;
   logic [31:0] oMeRData;
   logic        oMeErr;
   logic        oMeStall;
   logic        oMemReq;
   logic        oMemWe;
   logic [3:0]  oMemBe;
   logic [31:0] oMemAddr;
   logic [31:0] oMemWData;
   logic        iMemAck;
   logic [31:0] iMemRData;

   int   total = 0;
   int   bad = 0;
   int   mem_delay = 0;
   bit   spur = 1'b0;
   ack_t if_exp_q[$];
   ack_t me_exp_q[$];
   bus_t bus_exp_q[$];

   mem_bus_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .STARVE_MAX(4),
      .TIMEOUT(8)
   ) dut (
      .iClk(iClk),
      .iRst(iRst),
      .iIfReq(iIfReq),
      .iIfAddr(iIfAddr),
      .oIfAck(oIfAck),
      .oIfRData(oIfRData),
      .oIfErr(oIfErr),
      .oIfStall(oIfStall),
      .iMeReq(iMeReq),
      .iMeWe(iMeWe),
      .iMeBe(iMeBe),
      .iMeAddr(iMeAddr),
      .iMeWData(iMeWData),
      .oMeAck(oMeAck),
      .oMeRData(oMeRData),
      .oMeErr(oMeErr),
      .oMeStall(oMeStall),
      .oMemReq(oMemReq),
      .oMemWe(oMemWe),
      .oMemBe(oMemBe),
      .oMemAddr(oMemAddr),
      .oMemWData(oMemWData),
      .iMemAck(iMemAck),
      .iMemRData(iMemRData)
   );

   always #5 iClk = ~iClk;

   // Contents of the modelled memory; 0x100 holds 0xDEADBEEF.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hDEADBEEF ^ ((a - 32'h100) << 4);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
      end
   endtask

   task automatic nextCycle;
      @(posedge iClk);
      #1;
   endtask

   task automatic pushBus(input logic [31:0] addr, input logic we,
                          input logic [3:0] be, input logic [31:0] wdata);
      bus_t b;
      b.addr = addr; b.we = we; b.be = be; b.wdata = wdata;
      bus_exp_q.push_back(b);
   endtask

   // Holds an IF request until its ack; expLat is the cycle of the ack
   // counted from the issue cycle. Returns in the ack cycle.
   task automatic ifIssue(input logic [31:0] addr, input int expLat,
                          input logic [31:0] expData, input logic expErr);
      ack_t e;
      int   lat = 0;
      bit   got = 1'b0;
      e.rdata = expData; e.err = expErr;
      if_exp_q.push_back(e);
      iIfReq = 1'b1; iIfAddr = addr;
      while (!got && lat < 40) begin
         nextCycle;
         lat++;
         got = oIfAck;
         if (lat < expLat) begin
            checkOutput("if_ack_early", oIfAck, 0);
            checkOutput("if_stall_wait", oIfStall, 1);
         end else if (lat == expLat) begin
            checkOutput("if_ack_latency", oIfAck, 1);
            checkOutput("if_stall_at_ack", oIfStall, 0);
         end
      end
      checkOutput("if_ack_seen", got, 1);
   endtask

   task automatic meIssue(input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int expLat, input logic [31:0] expData,
                          input logic expErr);
      ack_t e;
      int   lat = 0;
      bit   got = 1'b0;
      e.rdata = expData; e.err = expErr;
      me_exp_q.push_back(e);
      iMeReq = 1'b1; iMeWe = we; iMeBe = be; iMeAddr = addr; iMeWData = wdata;
      while (!got && lat < 40) begin
         nextCycle;
         lat++;
         got = oMeAck;
         if (lat < expLat) begin
            checkOutput("me_ack_early", oMeAck, 0);
            checkOutput("me_stall_wait", oMeStall, 1);
         end else if (lat == expLat) begin
            checkOutput("me_ack_latency", oMeAck, 1);
            checkOutput("me_stall_at_ack", oMeStall, 0);
         end
      end
      checkOutput("me_ack_seen", got, 1);
   endtask

   task automatic checkQuiet(input string name);
      checkOutput(name, {29'd0, oMemReq, oIfAck, oMeAck}, 0);
   endtask

   task automatic applyStimulus(input int testId);
      case (testId)
         // Single IF fetch against a zero-wait memory.
         1: begin
            mem_delay = 1;
            pushBus(32'h100, 1'b0, 4'hF, 32'h0);
            ifIssue(32'h100, 2, 32'hDEADBEEF, 1'b0);
            nextCycle; iIfReq = 1'b0;
            nextCycle;
         end
         // IF held while ME streams five loads: IF forced in on the fifth.
         3: begin
            mem_delay = 1;
            for (int k = 0; k < 4; k++) pushBus(32'h500 + 32'(4 * k), 1'b0, 4'hF, 32'h0);
            pushBus(32'h108, 1'b0, 4'hF, 32'h0);
            pushBus(32'h510, 1'b0, 4'hF, 32'h0);
            fork
               begin
                  ifIssue(32'h108, 13, mem_word(32'h108), 1'b0);
                  nextCycle; iIfReq = 1'b0;
               end
               begin
                  for (int k = 0; k < 5; k++) begin
                     meIssue(1'b0, 4'hF, 32'h500 + 32'(4 * k), 32'h0, (k == 4) ? 3 : 2,
                             mem_word(32'h500 + 32'(4 * k)), 1'b0);
                     nextCycle;
                  end
                  iMeReq = 1'b0;
               end
            join
            nextCycle;
         end
         // Simultaneous IF fetch and ME store: ME first, store returns 0.
         2: begin
            mem_delay = 1;
            pushBus(32'h200, 1'b1, 4'b0011, 32'h1234);
            pushBus(32'h104, 1'b0, 4'hF, 32'h0);
            fork
               begin
                  ifIssue(32'h104, 5, mem_word(32'h104), 1'b0);
                  nextCycle; iIfReq = 1'b0;
               end
               begin
                  meIssue(1'b1, 4'b0011, 32'h200, 32'h1234, 2, 32'h0, 1'b0);
                  nextCycle; iMeReq = 1'b0;
               end
            join
            nextCycle;
         end
         // Spurious memory ack with no requests outstanding.
         6: begin
            spur = 1'b1;
            nextCycle;
            spur = 1'b0;
            for (int k = 0; k < 3; k++) begin
               nextCycle;
               checkQuiet("spurious_ack_quiet");
            end
         end
         // Reset while IF waits on a memory that never answers.
         5: begin
            mem_delay = 0;
            pushBus(32'h300, 1'b0, 4'hF, 32'h0);
            iIfReq = 1'b1; iIfAddr = 32'h300;
            nextCycle;
            checkOutput("rst_grant_active", oMemReq, 1);
            nextCycle;
            iRst = 1'b1; iIfReq = 1'b0;
            nextCycle;
            checkQuiet("rst_abandon");
            iRst = 1'b0;
            spur = 1'b1;
            nextCycle;
            spur = 1'b0;
            for (int k = 0; k < 3; k++) begin
               nextCycle;
               checkQuiet("rst_late_ack_quiet");
            end
            mem_delay = 1;
            pushBus(32'h10C, 1'b0, 4'hF, 32'h0);
            ifIssue(32'h10C, 2, mem_word(32'h10C), 1'b0);
            nextCycle; iIfReq = 1'b0;
            nextCycle;
         end
`ifdef ARB_TIMEOUT_EN
         // Abort after 8 silent grant cycles, then ack exactly at expiry.
         4: begin
            mem_delay = 0;
            pushBus(32'h400, 1'b0, 4'hF, 32'h0);
            meIssue(1'b0, 4'hF, 32'h400, 32'h0, 9, 32'h0, 1'b1);
            checkOutput("timeout_req_dropped", oMemReq, 0);
            nextCycle;
            mem_delay = 8;
            pushBus(32'h404, 1'b0, 4'hF, 32'h0);
            meIssue(1'b0, 4'hF, 32'h404, 32'h0, 9, mem_word(32'h404), 1'b0);
            nextCycle; iMeReq = 1'b0;
            mem_delay = 1;
            nextCycle;
            pushBus(32'h408, 1'b0, 4'hF, 32'h0);
            meIssue(1'b0, 4'hF, 32'h408, 32'h0, 2, mem_word(32'h408), 1'b0);
            nextCycle; iMeReq = 1'b0;
            nextCycle;
         end
`endif
         default: ;
      endcase
   endtask

   // Memory model: acks in the mem_delay-th cycle of a request.
   initial begin
      int gcnt;
      gcnt = 0;
      iMemAck = 1'b0; iMemRData = '0;
      forever begin
         @(posedge iClk);
         #1;
         if (spur) begin
            iMemAck = 1'b1; iMemRData = 32'hBAD0BAD0;
         end else if (oMemReq) begin
            gcnt++;
            iMemAck   = (gcnt == mem_delay);
            iMemRData = (gcnt == mem_delay) ? mem_word(oMemAddr) : 32'h0;
         end else begin
            gcnt = 0;
            iMemAck = 1'b0; iMemRData = '0;
         end
      end
   end

   // Monitor: pops expectations whenever the DUT acks or starts a bus access.
   initial begin
      ack_t e;
      bus_t cur;
      bit   bus_prev;
      bus_prev = 1'b0;
      cur = '{32'h0, 1'b0, 4'h0, 32'h0};
      forever begin
         @(negedge iClk);
         if (!iRst) begin
            checkOutput("single_ack", oIfAck & oMeAck, 0);
            if (oIfAck) begin
               checkOutput("if_ack_expected", if_exp_q.size() > 0, 1);
               if (if_exp_q.size() > 0) begin
                  e = if_exp_q.pop_front();
                  checkOutput("if_rdata", oIfRData, e.rdata);
                  checkOutput("if_err", oIfErr, e.err);
               end
            end
            if (oMeAck) begin
               checkOutput("me_ack_expected", me_exp_q.size() > 0, 1);
               if (me_exp_q.size() > 0) begin
                  e = me_exp_q.pop_front();
                  checkOutput("me_rdata", oMeRData, e.rdata);
                  checkOutput("me_err", oMeErr, e.err);
               end
            end
            if (oMemReq) begin
               if (!bus_prev) begin
                  checkOutput("bus_grant_expected", bus_exp_q.size() > 0, 1);
                  if (bus_exp_q.size() > 0) cur = bus_exp_q.pop_front();
               end
               checkOutput("bus_addr", oMemAddr, cur.addr);
               checkOutput("bus_we", oMemWe, cur.we);
               checkOutput("bus_be", oMemBe, cur.be);
               if (cur.we) checkOutput("bus_wdata", oMemWData, cur.wdata);
            end
         end
         bus_prev = oMemReq;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int order[6];
      order = '{1, 3, 2, 6, 5, 4};
      iRst = 1'b1; iIfReq = 1'b0; iIfAddr = '0;
      iMeReq = 1'b0; iMeWe = 1'b0; iMeBe = '0; iMeAddr = '0; iMeWData = '0;
      repeat (2) nextCycle;
      checkOutput("rst_mem_req", oMemReq, 0);
      checkOutput("rst_mem_addr", oMemAddr, 0);
      checkOutput("rst_if_ack", oIfAck, 0);
      checkOutput("rst_me_ack", oMeAck, 0);
      checkOutput("rst_if_rdata", oIfRData, 0);
      checkOutput("rst_me_rdata", oMeRData, 0);
      checkOutput("rst_errs", {oIfErr, oMeErr}, 0);
      iRst = 1'b0;
      nextCycle;
      for (int t = 0; t < 6; t++) applyStimulus(order[t]);
      repeat (3) nextCycle;
      checkOutput("if_queue_drained", if_exp_q.size(), 0);
      checkOutput("me_queue_drained", me_exp_q.size(), 0);
      checkOutput("bus_queue_drained", bus_exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
